// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset pulse, lock qualification and lock-loss supervisor on refclk
// Optional macro PLL_SUP_LOSS_FILTER_EN: RUN needs 4 consecutive unlocked cycles to declare loss.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       lock_lost,
   output logic [7:0] relock_count
);

   localparam int MAX_PS  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_ALL = (MAX_PS > LOCK_TIMEOUT_CYCLES) ? MAX_PS : LOCK_TIMEOUT_CYCLES;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   // Entry loads are N-1 so a state lasts N cycles; the reset load is N since reset itself is not an edge.
   localparam logic [CW-1:0] PULSE_RST = CW'(RST_PULSE_CYCLES);
   localparam logic [CW-1:0] PULSE_LD  = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LD = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LD    = CW'(LOCK_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_PULSE,
      S_WAIT_LOCK,
      S_QUALIFY,
      S_RUN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sync1_q, lk_s_q;
   logic            pll_rst_q, pll_rst_d;
   logic            sys_rst_n_q, sys_rst_n_d;
   logic            lock_lost_q, lock_lost_d;
   logic [7:0]      relock_count_q, relock_count_d;
   logic            loss;

`ifdef PLL_SUP_LOSS_FILTER_EN
   logic [1:0]      glitch_q, glitch_d;

   always_comb begin
      glitch_d = 2'd0;
      loss     = 1'b0;
      if (state_q == S_RUN && !lk_s_q) begin
         if (glitch_q == 2'd3) begin
            loss = 1'b1;
         end else begin
            glitch_d = glitch_q + 2'd1;
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= 2'd0;
      end else begin
         glitch_q <= glitch_d;
      end
   end
`else
   always_comb begin
      loss = (state_q == S_RUN) && !lk_s_q;
   end
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      lock_lost_d    = 1'b0;
      relock_count_d = relock_count_q;
      case (state_q)
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = TMO_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            // Lock arriving on the timeout cycle takes priority over re-pulsing.
            if (lk_s_q) begin
               state_d = S_QUALIFY;
               cnt_d   = STABLE_LD;
            end else if (cnt_q == '0) begin
               state_d = S_PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_QUALIFY: begin
            if (!lk_s_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = TMO_LD;
            end else if (cnt_q == '0) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            if (loss) begin
               state_d     = S_PULSE;
               cnt_d       = PULSE_LD;
               lock_lost_d = 1'b1;
               if (relock_count_q != 8'd255) begin
                  relock_count_d = relock_count_q + 8'd1;
               end
            end
         end
      endcase
      pll_rst_d   = (state_d == S_PULSE);
      sys_rst_n_d = (state_d == S_RUN);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_PULSE;
         cnt_q          <= PULSE_RST;
         sync1_q        <= 1'b0;
         lk_s_q         <= 1'b0;
         pll_rst_q      <= 1'b1;
         sys_rst_n_q    <= 1'b0;
         lock_lost_q    <= 1'b0;
         relock_count_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sync1_q        <= locked;
         lk_s_q         <= sync1_q;
         pll_rst_q      <= pll_rst_d;
         sys_rst_n_q    <= sys_rst_n_d;
         lock_lost_q    <= lock_lost_d;
         relock_count_q <= relock_count_d;
      end
   end

   assign pll_rst      = pll_rst_q;
   assign sys_rst_n    = sys_rst_n_q;
   assign lock_lost    = lock_lost_q;
   assign relock_count = relock_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

   localparam int P = 16;
   localparam int S = 64;
   localparam int T = 200;
`ifdef PLL_SUP_LOSS_FILTER_EN
   localparam int GL  = 4;
   localparam int LAT = 6;
`else
   localparam int GL  = 1;
   localparam int LAT = 3;
`endif

   logic       refclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic       locked = 1'b0;
   logic       pll_rst, sys_rst_n, lock_lost;
   logic [7:0] relock_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic ll_seen = 1'b0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES   (P),
      .LOCK_STABLE_CYCLES (S),
      .LOCK_TIMEOUT_CYCLES(T)
   ) dut (
      .refclk      (refclk),
      .rst_n       (rst_n),
      .locked      (locked),
      .pll_rst     (pll_rst),
      .sys_rst_n   (sys_rst_n),
      .lock_lost   (lock_lost),
      .relock_count(relock_count)
   );

   always #5 refclk = ~refclk;

   task automatic push(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge refclk);
         cyc++;
         ll_seen = ll_seen | lock_lost;
      end
   endtask

   task automatic to(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic async_reset_check(input string tag);
      #1 rst_n = 1'b0;
      push({tag, "_pll"}, 1); push({tag, "_sys"}, 0);
      push({tag, "_ll"}, 0);  push({tag, "_cnt"}, 0);
      #1;
      pop_chk(pll_rst); pop_chk(sys_rst_n); pop_chk(lock_lost); pop_chk(relock_count);
   endtask

   int  c;
   int  guard;
   logic ok;

   initial begin
      // Power-up
      tick(3);
      push("rst_pll", 1); push("rst_sys", 0); push("rst_ll", 0); push("rst_cnt", 0);
      pop_chk(pll_rst); pop_chk(sys_rst_n); pop_chk(lock_lost); pop_chk(relock_count);
      rst_n = 1'b1; cyc = 0;
      push("pwr_pll_hi", 1); push("pwr_pll_lo", 0);
      to(P);     pop_chk(pll_rst);
      to(P + 1); pop_chk(pll_rst);
      to(40); locked = 1'b1;
      push("pwr_sys_lo", 0); push("pwr_sys_hi", 1);
      to(40 + S + 2); pop_chk(sys_rst_n);
      to(40 + S + 3); pop_chk(sys_rst_n);

      // Lock loss in RUN
      c = 140;
      to(c); locked = 1'b0;
      push("loss_pre_ll", 0); push("loss_pre_sys", 1);
      push("loss_ll", 1); push("loss_sys", 0); push("loss_pll", 1); push("loss_cnt", 1);
      push("loss_ll_end", 0); push("repulse_hi", 1); push("repulse_lo", 0);
      push("relock_sys_lo", 0); push("relock_sys_hi", 1);
      to(c + GL); locked = 1'b1;
      to(c + LAT - 1); pop_chk(lock_lost); pop_chk(sys_rst_n);
      to(c + LAT);     pop_chk(lock_lost); pop_chk(sys_rst_n); pop_chk(pll_rst); pop_chk(relock_count);
      to(c + LAT + 1); pop_chk(lock_lost);
      to(c + LAT + P - 1); pop_chk(pll_rst);
      to(c + LAT + P);     pop_chk(pll_rst);
      to(c + LAT + P + S);     pop_chk(sys_rst_n);
      to(c + LAT + P + S + 1); pop_chk(sys_rst_n);

`ifdef PLL_SUP_LOSS_FILTER_EN
      // Three-cycle glitch must be ignored
      tick(5); ll_seen = 1'b0; locked = 1'b0;
      push("glitch_ll", 0); push("glitch_sys", 1); push("glitch_cnt", 1);
      tick(3); locked = 1'b1;
      tick(10);
      pop_chk(ll_seen); pop_chk(sys_rst_n); pop_chk(relock_count);
`endif

      // Saturation of relock_count
      ok = 1'b1;
      push("sat_progress", 1); push("sat_cnt", 255);
      for (int i = 0; i < 300; i++) begin
         tick(2); locked = 1'b0; tick(GL); locked = 1'b1;
         guard = 0;
         while (sys_rst_n !== 1'b0 && guard < 20) begin tick(1); guard++; end
         if (guard >= 20) ok = 1'b0;
         guard = 0;
         while (sys_rst_n !== 1'b1 && guard < S + P + 40) begin tick(1); guard++; end
         if (guard >= S + P + 40) ok = 1'b0;
      end
      pop_chk(ok); pop_chk(relock_count);

      // Reset taken in RUN, then in QUALIFY
      async_reset_check("rst_run");
      tick(2); rst_n = 1'b1; cyc = 0;
      push("qual_pll", 0); push("qual_sys", 0);
      to(29); pop_chk(pll_rst); pop_chk(sys_rst_n);
      async_reset_check("rst_qual");
      locked = 1'b0;
      tick(2); rst_n = 1'b1; cyc = 0; ll_seen = 1'b0;

      // Timeout re-pulsing with no lock
      push("tmo_w1", 0); push("tmo_p2_hi", 1); push("tmo_p2_end", 1); push("tmo_p2_lo", 0);
      push("tmo_w2", 0); push("tmo_p3_hi", 1);
      to(P + T);             pop_chk(pll_rst);
      to(P + T + 1);         pop_chk(pll_rst);
      to(2 * P + T);         pop_chk(pll_rst);
      to(2 * P + T + 1);     pop_chk(pll_rst);
      to(2 * P + 2 * T);     pop_chk(pll_rst);
      to(2 * P + 2 * T + 1); pop_chk(pll_rst);

      // Qualification abort
      c = 2 * P + 2 * T + P + 20;
      to(c); locked = 1'b1;
      to(c + 30); locked = 1'b0;
      to(c + 40); locked = 1'b1;
      push("abort_sys_mid", 0); push("abort_sys_lo", 0); push("abort_sys_hi", 1);
      push("abort_ll", 0); push("abort_cnt", 0);
      to(c + 60);         pop_chk(sys_rst_n);
      to(c + 40 + S + 2); pop_chk(sys_rst_n);
      to(c + 40 + S + 3); pop_chk(sys_rst_n);
      pop_chk(ll_seen); pop_chk(relock_count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervisor for the camera design's PLL clock wrappers. It drives the PLL's active-high `rst` input and consumes its asynchronous `locked` output. Clocked from the free-running 50 MHz reference, so it keeps running when the PLL output stops. It issues a timed PLL reset pulse and qualifies lock as stable before releasing the system reset. On lock loss it re-asserts the system reset, re-resets the PLL and counts relock events.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: refclk cycles `pll_rst` is held high per reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked-high cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles to wait for lock after a pulse before re-pulsing (1 ms at 50 MHz, ≥1).

Ports:
- `refclk`, input, 1: 50 MHz reference clock; sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `locked`, input, 1: PLL lock indication; asynchronous to `refclk`.
- `pll_rst`, output, 1: active-high reset to the PLL `rst` input.
- `sys_rst_n`, output, 1: active-low reset for logic on the PLL output clock.
- `lock_lost`, output, 1: one-cycle pulse when lock is lost in RUN.
- `relock_count`, output, 8: lock-loss event count; saturates at 255.

## Operation
- `locked` passes through a 2-flop synchronizer to give `lk_s`. All decisions use `lk_s`.
- There is one shared down-counter, sized to `$clog2` of the largest parameter plus 1. It is reloaded on every state entry.
- States and transitions:
  - PULSE: `pll_rst`=1, `sys_rst_n`=0. Stays for `RST_PULSE_CYCLES` cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0, `sys_rst_n`=0.
    - `lk_s`=1 goes to QUALIFY.
    - Otherwise, after `LOCK_TIMEOUT_CYCLES` cycles, goes to PULSE.
  - QUALIFY: `pll_rst`=0, `sys_rst_n`=0.
    - `lk_s`=0 goes to WAIT_LOCK, with the timeout reloaded in full.
    - After `LOCK_STABLE_CYCLES` consecutive `lk_s`=1 cycles, goes to RUN.
  - RUN: `pll_rst`=0, `sys_rst_n`=1.
    - A lock-loss decision pulses `lock_lost` and goes to PULSE.
    - `relock_count` increments on the same edge, unless it is already 255.
- A timeout with no lock is not a lock-loss event: no `lock_lost` pulse and no count change.
- If the timeout expiry and `lk_s` rising occur in the same cycle, `lk_s` wins and the state goes to QUALIFY.
- `relock_count` clears only on `rst_n`.
- All outputs are registered.

## Timing
- Reset values, held while `rst_n`=0:
  - state = PULSE
  - `pll_rst`=1
  - `sys_rst_n`=0
  - `lock_lost`=0
  - `relock_count`=0
  - synchronizer flops = 0
  - counter loaded with `RST_PULSE_CYCLES`
- After `rst_n` rises, `pll_rst` stays high for exactly `RST_PULSE_CYCLES` rising edges and falls on the following edge.
- `locked` reaches `lk_s` 2 edges after it changes.
- `sys_rst_n` rises on the edge `LOCK_STABLE_CYCLES` cycles after QUALIFY entry. That is `LOCK_STABLE_CYCLES`+3 edges after `locked` rises, with the state in WAIT_LOCK and `locked` held high.
- Loss without the filter:
  - `sys_rst_n` falls, `lock_lost`=1 and `pll_rst` rises on the edge after the first `lk_s`=0 in RUN. That is 3 edges after `locked` falls.
  - `lock_lost` returns to 0 on the next edge.
- Reset taken mid-operation, in any state, forces the reset values immediately and asynchronously.

## Configuration
- Macro: `PLL_SUP_LOSS_FILTER_EN`.
- When defined:
  - RUN declares lock loss only after 4 consecutive `lk_s`=0 cycles. Loss is then 6 edges after `locked` falls.
  - Shorter low glitches are ignored: no pulse, no count change, `sys_rst_n` stays 1.
  - The glitch counter clears on any `lk_s`=1.
- When undefined: a single `lk_s`=0 cycle in RUN is a loss.
- Behaviour outside RUN is identical with and without the macro.

## Test plan
- Power-up, default parameters: release `rst_n`, raise `locked` at cycle 40 → `pll_rst` high cycles 1–16, low from 17; `sys_rst_n` rises at cycle 40+1027.
- Timeout: hold `locked`=0 → `pll_rst` re-pulses every 16+50000 cycles; `lock_lost`=0; `relock_count`=0.
- Qualification abort: `locked` high for 500 cycles, low for 10, then high → `sys_rst_n` stays 0 until 1027 edges after the second rise.
- Lock loss in RUN, filter off: drop `locked` for 1 cycle → 3 edges later `sys_rst_n`=0 with a one-cycle `lock_lost`; `relock_count`=1; a new 16-cycle `pll_rst` pulse follows. Repeat 300 times → `relock_count` holds at 255.
- Filter on: 3-cycle low glitch → no `lock_lost`, `sys_rst_n` stays 1. 4-cycle low → loss declared 6 edges after the fall.
- Mid-operation reset: assert `rst_n`=0 during QUALIFY and during RUN → outputs take their reset values without waiting for a clock edge; `relock_count` clears to 0.
